carpma_denetleyici: RTL and testbench

//  Execute-stage issue/sequencing unit that sits directly upstream of carpma_birimi. Accepts RV32M multiply requests
//  (funct3 + operands) from decode via valid/ready, maps funct3 to the 2-bit CARPMA_* control code, drives and holds
//  the multiplier's operands, steps its durdur_i through the fixed pipeline latency, then freezes and presents the
//  32-bit result to writeback via valid/ready.

---
 rtl/carpma_denetleyici_pkg.sv | 24 ++
 rtl/carpma_denetleyici.sv | 125 ++++++++++++
 tb/tb_carpma_denetleyici.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/carpma_denetleyici_pkg.sv
// Shared definitions for the multiply issue unit: carpma_birimi control codes,
// RV32M funct3 encodings and the sequencer state type.
package carpma_denetleyici_pkg;

   localparam logic [1:0] CARPMA_MUL    = 2'b00;
   localparam logic [1:0] CARPMA_MULH   = 2'b01;
   localparam logic [1:0] CARPMA_MULHSU = 2'b10;
   localparam logic [1:0] CARPMA_MULHU  = 2'b11;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;

   // Wide enough for GECIKME-1 with GECIKME up to 7.
   localparam int unsigned SAYAC_W = 3;

   typedef enum logic [1:0] {
      CD_BOSTA   = 2'd0,
      CD_HESAPLA = 2'd1,
      CD_SONUC   = 2'd2
   } cd_durum_e;

endpackage

// File: rtl/carpma_denetleyici.sv
// Issue/sequencing unit in front of carpma_birimi: accepts RV32M multiply requests,
// steps the multiplier through GECIKME cycles and holds the result for writeback.
// Optional zero-operand bypass: define CARPMA_SIFIR_ATLA_EN.
module carpma_denetleyici
   import carpma_denetleyici_pkg::*;
#(
   parameter int unsigned GECIKME = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        temizle_i,
   input  logic        istek_gecerli_i,
   output logic        istek_hazir_o,
   input  logic [2:0]  istek_funct3_i,
   input  logic [31:0] istek_deger1_i,
   input  logic [31:0] istek_deger2_i,
   output logic [1:0]  carp_kontrol_o,
   output logic [31:0] carp_deger1_o,
   output logic [31:0] carp_deger2_o,
   output logic        carp_durdur_o,
   input  logic [31:0] carp_sonuc_i,
   output logic        sonuc_gecerli_o,
   input  logic        sonuc_hazir_i,
   output logic [31:0] sonuc_o
);

   function automatic logic [1:0] kontrol_esle(input logic [2:0] f3);
      logic [1:0] k;
      case (f3)
         F3_MULH:   k = CARPMA_MULH;
         F3_MULHSU: k = CARPMA_MULHSU;
         F3_MULHU:  k = CARPMA_MULHU;
         default:   k = CARPMA_MUL;
      endcase
      return k;
   endfunction

   cd_durum_e          durum_q;
   logic [SAYAC_W-1:0] sayac_q;
   logic [1:0]         kontrol_q;
   logic [1:0]         kontrol_d;
   logic [31:0]        deger1_q;
   logic [31:0]        deger2_q;
   logic               durdur_q;
   logic               gecerli_q;
   logic               sifir_q;

   logic               hazir;
   logic               kabul;
   logic               atla_d;

   assign hazir     = (durum_q == CD_BOSTA) | ((durum_q == CD_SONUC) & sonuc_hazir_i);
   assign kabul     = istek_gecerli_i & hazir & ~temizle_i;
   assign kontrol_d = kontrol_esle(istek_funct3_i);

`ifdef CARPMA_SIFIR_ATLA_EN
   assign atla_d = istek_funct3_i[2] | (istek_deger1_i == '0) | (istek_deger2_i == '0);
`else
   assign atla_d = istek_funct3_i[2];
`endif

   // Accept is only possible from BOSTA or a retiring SONUC, so it is handled
   // ahead of the per-state transitions.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum_q   <= CD_BOSTA;
         sayac_q   <= '0;
         kontrol_q <= '0;
         deger1_q  <= '0;
         deger2_q  <= '0;
         durdur_q  <= 1'b1;
         gecerli_q <= 1'b0;
         sifir_q   <= 1'b0;
      end else if (temizle_i) begin
         durum_q   <= CD_BOSTA;
         durdur_q  <= 1'b1;
         gecerli_q <= 1'b0;
      end else if (kabul) begin
         kontrol_q <= kontrol_d;
         deger1_q  <= istek_deger1_i;
         deger2_q  <= istek_deger2_i;
         sayac_q   <= SAYAC_W'(GECIKME - 1);
         sifir_q   <= atla_d;
         if (atla_d) begin
            durum_q   <= CD_SONUC;
            durdur_q  <= 1'b1;
            gecerli_q <= 1'b1;
         end else begin
            durum_q   <= CD_HESAPLA;
            durdur_q  <= 1'b0;
            gecerli_q <= 1'b0;
         end
      end else begin
         case (durum_q)
            CD_HESAPLA: begin
               if (sayac_q == '0) begin
                  durum_q   <= CD_SONUC;
                  durdur_q  <= 1'b1;
                  gecerli_q <= 1'b1;
               end else begin
                  sayac_q <= sayac_q - 1'b1;
               end
            end
            CD_SONUC: begin
               if (sonuc_hazir_i) begin
                  durum_q   <= CD_BOSTA;
                  gecerli_q <= 1'b0;
               end
            end
            default: begin
               durum_q <= CD_BOSTA;
            end
         endcase
      end
   end

   assign istek_hazir_o   = hazir;
   assign carp_kontrol_o  = kontrol_q;
   assign carp_deger1_o   = deger1_q;
   assign carp_deger2_o   = deger2_q;
   assign carp_durdur_o   = durdur_q;
   assign sonuc_gecerli_o = gecerli_q;
   assign sonuc_o         = (gecerli_q & ~sifir_q) ? carp_sonuc_i : '0;

endmodule

// File: tb/tb_carpma_denetleyici.sv
// Bench for carpma_denetleyici with a behavioural single-cycle multiplier
// standing in for carpma_birimi (FPGA path, GECIKME=1).
module tb_carpma_denetleyici;

   logic        clk;
   logic        rst_n;
   logic        temizle;
   logic        gecerli;
   logic        hazir_o;
   logic [2:0]  funct3;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [1:0]  kontrol;
   logic [31:0] cd1;
   logic [31:0] cd2;
   logic        durdur;
   logic [31:0] carp_sonuc;
   logic        sonuc_gecerli;
   logic        sonuc_hazir;
   logic [31:0] sonuc;

   logic [31:0] beklenen_q[$];
   int          toplam;
   int          hata;

   carpma_denetleyici #(.GECIKME(1)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .temizle_i       (temizle),
      .istek_gecerli_i (gecerli),
      .istek_hazir_o   (hazir_o),
      .istek_funct3_i  (funct3),
      .istek_deger1_i  (d1),
      .istek_deger2_i  (d2),
      .carp_kontrol_o  (kontrol),
      .carp_deger1_o   (cd1),
      .carp_deger2_o   (cd2),
      .carp_durdur_o   (durdur),
      .carp_sonuc_i    (carp_sonuc),
      .sonuc_gecerli_o (sonuc_gecerli),
      .sonuc_hazir_i   (sonuc_hazir),
      .sonuc_o         (sonuc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RV32M reference: funct3 selects product half and operand signedness.
   function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] sa, ua, sb, ub, p;
      sa = {{32{a[31]}}, a};
      ua = {32'b0, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      case (f3)
         3'b000:  begin p = sa * sb; return p[31:0];  end
         3'b001:  begin p = sa * sb; return p[63:32]; end
         3'b010:  begin p = sa * ub; return p[63:32]; end
         3'b011:  begin p = ua * ub; return p[63:32]; end
         default: return 32'h0;
      endcase
   endfunction

   // Multiplier model: kontrol 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; frozen while durdur=1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) carp_sonuc <= 32'h0;
      else if (!durdur) carp_sonuc <= ref_mul({1'b0, kontrol}, cd1, cd2);
   end

   task automatic istek_gonder(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input bit kaydet);
      funct3  = f3;
      d1      = a;
      d2      = b;
      gecerli = 1'b1;
      if (kaydet) beklenen_q.push_back(ref_mul(f3, a, b));
      @(negedge clk);
      gecerli = 1'b0;
   endtask

   task automatic sonuc_bekle(output int lat);
      lat = 0;
      while (sonuc_gecerli !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; temizle = 1'b0; gecerli = 1'b0; sonuc_hazir = 1'b1;
      funct3 = '0; d1 = '0; d2 = '0;
      repeat (2) @(negedge clk);
      toplam++; if (hazir_o !== 1'b1) begin hata++; $display("FAIL reset_hazir got %b want 1", hazir_o); end
      toplam++; if (sonuc_gecerli !== 1'b0) begin hata++; $display("FAIL reset_gecerli got %b want 0", sonuc_gecerli); end
      toplam++; if (durdur !== 1'b1) begin hata++; $display("FAIL reset_durdur got %b want 1", durdur); end
      toplam++; if (sonuc !== 32'h0) begin hata++; $display("FAIL reset_sonuc got %h want 0", sonuc); end
      toplam++; if ({kontrol, cd1, cd2} !== 66'h0) begin hata++; $display("FAIL reset_regs got %h want 0", {kontrol, cd1, cd2}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul;
      logic [2:0]  f3s[8];
      logic [31:0] as[8];
      logic [31:0] bs[8];
      logic [31:0] exp;
      int          lat;
      f3s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
      as  = '{32'd7, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0, 0};
      bs  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0};
      for (int unsigned i = 4; i < 8; i++) begin
         as[i] = $urandom | 32'h1;
         bs[i] = $urandom | 32'h100;
      end
      for (int unsigned i = 0; i < 8; i++) begin
         istek_gonder(f3s[i], as[i], bs[i], 1'b1);
         toplam++; if (durdur !== 1'b0) begin hata++; $display("FAIL mul_durdur[%0d] got %b want 0", i, durdur); end
         toplam++; if (kontrol !== f3s[i][1:0]) begin hata++; $display("FAIL mul_kontrol[%0d] got %b want %b", i, kontrol, f3s[i][1:0]); end
         toplam++; if (cd1 !== as[i] || cd2 !== bs[i]) begin hata++; $display("FAIL mul_operand[%0d] got %h/%h want %h/%h", i, cd1, cd2, as[i], bs[i]); end
         sonuc_bekle(lat);
         toplam++; if (lat !== 1) begin hata++; $display("FAIL mul_latency[%0d] got %0d want 1", i, lat); end
         exp = beklenen_q.pop_front();
         toplam++; if (sonuc !== exp) begin hata++; $display("FAIL mul_sonuc[%0d] got %h want %h", i, sonuc, exp); end
         @(negedge clk);
         toplam++; if (sonuc_gecerli !== 1'b0) begin hata++; $display("FAIL mul_retire[%0d] got %b want 0", i, sonuc_gecerli); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp;
      int          lat;
      sonuc_hazir = 1'b0;
      istek_gonder(3'd0, 32'h00012345, 32'h00006789, 1'b1);
      sonuc_bekle(lat);
      exp = beklenen_q.pop_front();
      toplam++; if (sonuc !== exp) begin hata++; $display("FAIL bp_sonuc got %h want %h", sonuc, exp); end
      repeat (5) begin
         @(negedge clk);
         toplam++; if (sonuc !== exp || sonuc_gecerli !== 1'b1) begin hata++; $display("FAIL bp_hold got %h/%b want %h/1", sonuc, sonuc_gecerli, exp); end
         toplam++; if (durdur !== 1'b1 || hazir_o !== 1'b0) begin hata++; $display("FAIL bp_ctrl got durdur=%b hazir=%b want 1/0", durdur, hazir_o); end
      end
      sonuc_hazir = 1'b1;
      funct3 = 3'd3; d1 = 32'hFFFF0000; d2 = 32'h0001FFFF; gecerli = 1'b1;
      beklenen_q.push_back(ref_mul(3'd3, 32'hFFFF0000, 32'h0001FFFF));
      #1;
      toplam++; if (hazir_o !== 1'b1) begin hata++; $display("FAIL b2b_hazir got %b want 1", hazir_o); end
      @(negedge clk);
      gecerli = 1'b0;
      toplam++; if (sonuc_gecerli !== 1'b0 || durdur !== 1'b0) begin hata++; $display("FAIL b2b_state got gecerli=%b durdur=%b want 0/0", sonuc_gecerli, durdur); end
      sonuc_bekle(lat);
      exp = beklenen_q.pop_front();
      toplam++; if (lat !== 1 || sonuc !== exp) begin hata++; $display("FAIL b2b_sonuc got %h lat %0d want %h lat 1", sonuc, lat, exp); end
      @(negedge clk);
   endtask

   task automatic test_temizle;
      logic [31:0] exp;
      int          lat;
      istek_gonder(3'd0, 32'd11, 32'd13, 1'b0);
      temizle = 1'b1;
      @(negedge clk);
      temizle = 1'b0;
      toplam++; if (sonuc_gecerli !== 1'b0 || durdur !== 1'b1 || hazir_o !== 1'b1) begin
         hata++; $display("FAIL flush_hesapla got gecerli=%b durdur=%b hazir=%b want 0/1/1", sonuc_gecerli, durdur, hazir_o);
      end
      repeat (3) begin
         @(negedge clk);
         toplam++; if (sonuc_gecerli !== 1'b0) begin hata++; $display("FAIL flush_nopulse got %b want 0", sonuc_gecerli); end
      end
      gecerli = 1'b1; temizle = 1'b1;
      @(negedge clk);
      gecerli = 1'b0; temizle = 1'b0;
      toplam++; if (durdur !== 1'b1 || sonuc_gecerli !== 1'b0) begin hata++; $display("FAIL flush_noaccept got durdur=%b gecerli=%b want 1/0", durdur, sonuc_gecerli); end
      sonuc_hazir = 1'b0;
      istek_gonder(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
      sonuc_bekle(lat);
      temizle = 1'b1;
      @(negedge clk);
      temizle = 1'b0; sonuc_hazir = 1'b1;
      toplam++; if (sonuc_gecerli !== 1'b0 || sonuc !== 32'h0) begin hata++; $display("FAIL flush_sonuc got %b/%h want 0/0", sonuc_gecerli, sonuc); end
      istek_gonder(3'd0, 32'd100, 32'hFFFFFFF9, 1'b1);
      sonuc_bekle(lat);
      exp = beklenen_q.pop_front();
      toplam++; if (lat !== 1 || sonuc !== exp) begin hata++; $display("FAIL flush_after got %h lat %0d want %h lat 1", sonuc, lat, exp); end
      @(negedge clk);
   endtask

   task automatic test_illegal;
      logic [2:0]  f3s[2];
      logic [31:0] exp;
      int          lat;
      f3s = '{3'b100, 3'b111};
      for (int unsigned i = 0; i < 2; i++) begin
         istek_gonder(f3s[i], 32'd5, 32'd6, 1'b1);
         toplam++; if (durdur !== 1'b1) begin hata++; $display("FAIL illegal_durdur[%0d] got %b want 1", i, durdur); end
         sonuc_bekle(lat);
         exp = beklenen_q.pop_front();
         toplam++; if (lat !== 0 || sonuc !== exp) begin hata++; $display("FAIL illegal_sonuc[%0d] got %h lat %0d want %h lat 0", i, sonuc, lat, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset;
      logic [31:0] exp;
      int          lat;
      sonuc_hazir = 1'b0;
      istek_gonder(3'd0, 32'd9, 32'd9, 1'b0);
      sonuc_bekle(lat);
      #2 rst_n = 1'b0;
      #1;
      toplam++; if (sonuc_gecerli !== 1'b0 || hazir_o !== 1'b1 || durdur !== 1'b1) begin
         hata++; $display("FAIL arst_ctrl got gecerli=%b hazir=%b durdur=%b want 0/1/1", sonuc_gecerli, hazir_o, durdur);
      end
      toplam++; if (sonuc !== 32'h0 || {kontrol, cd1, cd2} !== 66'h0) begin hata++; $display("FAIL arst_data got %h/%h want 0/0", sonuc, {kontrol, cd1, cd2}); end
      @(negedge clk);
      rst_n = 1'b1; sonuc_hazir = 1'b1;
      repeat (2) begin
         @(negedge clk);
         toplam++; if (sonuc_gecerli !== 1'b0) begin hata++; $display("FAIL arst_noresult got %b want 0", sonuc_gecerli); end
      end
      istek_gonder(3'd2, 32'hFFFFFFF0, 32'h00000010, 1'b1);
      sonuc_bekle(lat);
      exp = beklenen_q.pop_front();
      toplam++; if (lat !== 1 || sonuc !== exp) begin hata++; $display("FAIL arst_after got %h lat %0d want %h lat 1", sonuc, lat, exp); end
      @(negedge clk);
   endtask

   task automatic test_sifir;
      logic [31:0] exp;
      int          lat;
      istek_gonder(3'd0, 32'd0, 32'd5, 1'b1);
`ifdef CARPMA_SIFIR_ATLA_EN
      toplam++; if (durdur !== 1'b1) begin hata++; $display("FAIL sifir_durdur got %b want 1", durdur); end
      sonuc_bekle(lat);
      toplam++; if (lat !== 0) begin hata++; $display("FAIL sifir_latency got %0d want 0", lat); end
`else
      toplam++; if (durdur !== 1'b0) begin hata++; $display("FAIL sifir_durdur got %b want 0", durdur); end
      sonuc_bekle(lat);
      toplam++; if (lat !== 1) begin hata++; $display("FAIL sifir_latency got %0d want 1", lat); end
`endif
      exp = beklenen_q.pop_front();
      toplam++; if (sonuc !== exp) begin hata++; $display("FAIL sifir_sonuc got %h want %h", sonuc, exp); end
      @(negedge clk);
   endtask

   initial begin
      toplam = 0;
      hata   = 0;
      test_reset;
      test_mul;
      test_back_to_back;
      test_temizle;
      test_illegal;
      test_async_reset;
      test_sifir;
      toplam++; if (beklenen_q.size() !== 0) begin hata++; $display("FAIL scoreboard_left got %0d want 0", beklenen_q.size()); end
      $display("test done: total=%0d bad=%0d", toplam, hata);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
